// File: rtl/iob_fifo_sync_stream_rd.sv
// Read-side stream adapter for the synchronous FIFO: 3-entry prefetch buffer, valid/ready output.
// Optional burst framing (m_last, burst_len) enabled by IOB_FIFO_SYNC_STREAM_RD_LAST_EN.
module iob_fifo_sync_stream_rd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              ap_clk,
    input  logic              arst,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_r_data,
    input  logic              fifo_r_empty,
    input  logic [ADDR_W:0]   fifo_level,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
    input  logic [15:0]       burst_len,
    output logic              m_last,
`endif
    output logic [ADDR_W+2:0] level
);

    logic [DATA_W-1:0] mem_q [3];
    logic [1:0]        rd_ptr_q;
    logic [1:0]        wr_ptr_q;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              inflight_q;
    logic              pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue depends only on registered state, so m_ready never reaches fifo_r_en.
    always_comb begin
        m_valid   = (occ_q != 2'd0);
        m_data    = mem_q[rd_ptr_q];
        pop       = m_valid & m_ready;
        fifo_r_en = ~arst & ~fifo_r_empty &
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
        occ_d     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        level     = {2'b00, fifo_level}
                  + {{(ADDR_W+1){1'b0}}, occ_q}
                  + {{(ADDR_W+2){1'b0}}, inflight_q};
    end

    always_ff @(posedge ap_clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= fifo_r_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            occ_q      <= occ_d;
            inflight_q <= fifo_r_en;
        end
    end

`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
    logic [15:0] cnt_q;
    logic [15:0] blen_q;
    logic [15:0] blen_cur;
    logic [15:0] last_idx;

    // The first beat of a burst sees the live burst_len; later beats use the copy taken then.
    always_comb begin
        blen_cur = (cnt_q == 16'd0) ? burst_len : blen_q;
        last_idx = (blen_cur == 16'd0) ? 16'd0 : blen_cur - 16'd1;
        m_last   = m_valid & (cnt_q == last_idx);
    end

    always_ff @(posedge ap_clk or posedge arst) begin
        if (arst) begin
            cnt_q  <= 16'd0;
            blen_q <= 16'd0;
        end else if (pop) begin
            if (cnt_q == 16'd0) blen_q <= burst_len;
            cnt_q <= m_last ? 16'd0 : cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iob_fifo_sync_stream_rd.sv
// Bench for iob_fifo_sync_stream_rd: behavioural FIFO plus word-order/count reference model.
// Build with IOB_FIFO_SYNC_STREAM_RD_LAST_EN defined to also check m_last framing.
module tb_iob_fifo_sync_stream_rd;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              ap_clk = 1'b0;
    logic              arst;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_r_data;
    logic              fifo_r_empty;
    logic [ADDR_W:0]   fifo_level;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [ADDR_W+2:0] level;
`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
    logic [15:0]       burst_len;
    logic              m_last;
`endif

    always #5 ap_clk = ~ap_clk;

    iob_fifo_sync_stream_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .ap_clk       (ap_clk),
        .arst         (arst),
        .fifo_r_en    (fifo_r_en),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_empty (fifo_r_empty),
        .fifo_level   (fifo_level),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
        .burst_len    (burst_len),
        .m_last       (m_last),
`endif
        .level        (level)
    );

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] expq[$];
    int out_n;
    int prev_en;
    int cyc_n;
    int hs_cnt, en_cnt, first_hs, last_hs, first_valid;
    int beat;
    int bl_held;
    int last_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_r_empty = (fq.size() == 0);
        fifo_level   = fq.size();
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fq.push_back(w);
        expq.push_back(w);
        fifo_sync();
    endtask

    task automatic clr_stats();
        hs_cnt = 0; en_cnt = 0; first_hs = -1; last_hs = -1; first_valid = -1; last_cnt = 0;
    endtask

    task automatic model_reset();
        fq.delete();
        expq.delete();
        out_n = 0; prev_en = 0; beat = 0; bl_held = 0;
        fifo_r_data = '0;
        fifo_sync();
    endtask

    // One clock: check outputs against the reference, advance the edge, then play the FIFO.
    task automatic cyc();
        logic en, hs;
        #2;
        en = fifo_r_en;
        hs = m_valid & m_ready;
        chk("r_en", en, (arst == 1'b0 && fq.size() != 0 && out_n < 3));
        chk("m_valid", m_valid, ((out_n - prev_en) > 0));
        chk("level", level, fq.size() + out_n);
        if (m_valid) begin
            if (first_valid < 0) first_valid = cyc_n;
            if (expq.size() == 0) chk("spurious_valid", m_valid, 0);
            else chk("m_data", m_data, expq[0]);
        end
`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
        begin
            int cur, eff;
            cur = (beat == 0) ? int'(burst_len) : bl_held;
            eff = (cur == 0) ? 1 : cur;
            if (m_valid) chk("m_last", m_last, (beat == eff - 1));
            if (hs) begin
                if (beat == 0) bl_held = int'(burst_len);
                if (beat == eff - 1) begin beat = 0; last_cnt++; end
                else beat++;
            end
        end
`endif
        if (hs) begin
            if (expq.size() != 0) void'(expq.pop_front());
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc_n;
            last_hs = cyc_n;
        end
        if (en) en_cnt++;
        @(posedge ap_clk);
        #1;
        if (en) begin
            if (fq.size() == 0) chk("pop_on_empty", en, 0);
            else fifo_r_data = fq.pop_front();
        end
        out_n   = out_n + int'(en) - int'(hs);
        prev_en = int'(en);
        cyc_n++;
        fifo_sync();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        arst = 1'b1;
        m_ready = 1'b0;
        cyc_n = 0;
`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
        burst_len = 16'd4;
`endif
        model_reset();
        clr_stats();
        #3;
        chk("rst_r_en", fifo_r_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_level", level, 0);
        @(posedge ap_clk); #1;
        arst = 1'b0;
        run(2);

        // Three-word preload, consumer always ready.
        m_ready = 1'b1;
        clr_stats();
        begin
            int c0;
            c0 = cyc_n;
            push_word(32'h11); push_word(32'h22); push_word(32'h33);
            run(8);
            chk("first_latency", first_valid - c0, 2);
            chk("t1_hs", hs_cnt, 3);
            chk("t1_consec", last_hs - first_hs, 2);
        end

        // 16-word stream at full rate.
        clr_stats();
        for (int i = 0; i < 16; i++) push_word($urandom);
        run(22);
        chk("t2_hs", hs_cnt, 16);
        chk("t2_consec", last_hs - first_hs, 15);

        // Backpressure: buffer fills, issue stops.
        m_ready = 1'b0;
        clr_stats();
        for (int i = 0; i < 8; i++) push_word($urandom);
        run(10);
        chk("t3_issue_cnt", en_cnt, 3);
        chk("t3_level", level, 8);
        m_ready = 1'b1;
        run(14);
        chk("t3_drain", hs_cnt, 8);

        // Alternating ready.
        clr_stats();
        for (int i = 0; i < 6; i++) push_word($urandom);
        for (int i = 0; i < 16; i++) begin
            m_ready = ~i[0];
            cyc();
        end
        chk("t4_hs", hs_cnt, 6);

        // Random traffic.
        m_ready = 1'b1;
        clr_stats();
        for (int i = 0; i < 300; i++) begin
            if (fq.size() < 14 && $urandom_range(0, 2) == 0) push_word($urandom);
            m_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        m_ready = 1'b1;
        run(25);
        chk("rand_drained", m_valid, 0);

        // Reset with occ=2, inflight=1 and words still in the FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word($urandom);
        run(3);
        arst = 1'b1;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_r_en", fifo_r_en, 0);
        chk("mid_rst_level", level, fq.size());
        model_reset();
        @(posedge ap_clk); #1;
        arst = 1'b0;
        m_ready = 1'b1;
        clr_stats();
        push_word(32'hCAFE0001); push_word(32'hCAFE0002);
        run(8);
        chk("post_rst_hs", hs_cnt, 2);

`ifdef IOB_FIFO_SYNC_STREAM_RD_LAST_EN
        burst_len = 16'd4;
        clr_stats();
        for (int i = 0; i < 8; i++) push_word($urandom);
        run(14);
        chk("bl4_lasts", last_cnt, 2);
        burst_len = 16'd0;
        clr_stats();
        for (int i = 0; i < 5; i++) push_word($urandom);
        run(10);
        chk("bl0_lasts", last_cnt, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/iob_fifo_sync_stream_rd.md
Name: iob_fifo_sync_stream_rd

Overview:
- Read-side companion for the synchronous FIFO. Drains the FIFO read port (r_en / r_data / r_empty, 1-cycle read latency) and presents the words as a valid/ready stream.
- A 3-entry prefetch buffer sustains 1 word/cycle with no combinational path from m_ready to fifo_r_en.
- Sits between the FIFO and downstream consumers such as cache fill and AXI write-data paths.

Parameters:
- DATA_W, 32, FIFO read data width (R_DATA_W of the FIFO) and stream width.
- ADDR_W, 4, FIFO address width; FIFO level input is ADDR_W+1 bits.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- arst  in  1  asynchronous, active-high reset.
- fifo_r_en  out  1  FIFO pop request.
- fifo_r_data  in  DATA_W  FIFO read data, valid 1 cycle after fifo_r_en.
- fifo_r_empty  in  1  FIFO empty flag.
- fifo_level  in  ADDR_W+1  FIFO occupancy in R_DATA_W words.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_W  stream word.
- m_ready  in  1  consumer accepts word.
- level  out  ADDR_W+3  total words pending: fifo_level + occ + inflight.

Behaviour:
- Reset is asynchronous, active-high on arst. Reset values: fifo_r_en=0, m_valid=0, m_data=0, occ=0, inflight=0, level=fifo_level.
- State:
  - occ (0..3) = valid entries in the circular buffer.
  - rd_ptr, wr_ptr (2 bits, wrap 2->0).
  - inflight (1 bit) = fifo_r_en was asserted last cycle.
- Issue rule: fifo_r_en = ~fifo_r_empty & (occ + inflight < 3). It depends only on registered state and fifo_r_empty, never on m_ready.
- Capture: when inflight=1, fifo_r_data is written at wr_ptr and wr_ptr advances. Next inflight = fifo_r_en.
- Output:
  - m_valid = (occ != 0); m_data = buffer[rd_ptr].
  - Buffer entries are registers, so m_data is glitch-free.
- Pop: on m_valid & m_ready, rd_ptr advances.
- Occupancy update: occ_next = occ + inflight - (m_valid & m_ready). Simultaneous capture and pop leaves occ unchanged.
- Handshake: once m_valid=1, m_data is held stable until accepted. m_valid never drops without a handshake.
- Latency and throughput:
  - First word: m_valid rises 2 cycles after fifo_r_empty falls (issue cycle, then capture).
  - Steady state with m_ready=1: occ=1, inflight=1, 1 word/cycle.
- Boundaries:
  - occ+inflight=3 → fifo_r_en=0. Overflow is impossible by construction.
  - fifo_r_empty=1 → no issue; buffered words continue to drain.
  - m_ready held low → buffer fills to 3 and issue stops. The FIFO level then stays constant.
  - arst mid-stream → buffer contents discarded, including any in-flight word. A word popped from the FIFO but not yet captured is lost. Callers must reset the FIFO together with this block.
- Width: level arithmetic is performed at ADDR_W+3 bits, with no truncation.

Optional Feature:
- Macro: IOB_FIFO_SYNC_STREAM_RD_LAST_EN.
- When defined:
  - Adds port burst_len (in, 16) and port m_last (out, 1, reset 0).
  - A 16-bit beat counter increments on each handshake.
  - m_last=1 when cnt == burst_len-1. On a handshake with m_last=1, cnt returns to 0.
  - burst_len is sampled when cnt==0 and the first beat of a burst is accepted; it is held for the rest of the burst.
  - burst_len=0 is treated as 1, so every beat is last.
  - Counter resets to 0 on arst.
- When undefined: burst_len, m_last and the counter are absent. Stream and level behaviour are identical.

Test Plan:
- Reset then preload FIFO with 0x11,0x22,0x33, m_ready=1 → m_valid rises 2 cycles after empty deasserts. Data 0x11,0x22,0x33 appears on consecutive cycles, then m_valid=0.
- 16 words streaming, m_ready=1 throughout → 16 handshakes in 16 consecutive cycles after first valid; fifo_r_en high every cycle while FIFO non-empty.
- FIFO holds 8 words, m_ready=0 → fifo_r_en pulses exactly 3 times, occ=3, m_data=word0 stable, level=8 throughout. Releasing m_ready drains all 8 in order.
- m_ready toggling 1,0,1,0 with 6 words → no word lost or duplicated; m_data stable during every m_ready=0 cycle.
- arst asserted while occ=2, inflight=1 → m_valid=0 and fifo_r_en=0 immediately. After release with a fresh FIFO, the first word is correct.
- With LAST_EN, burst_len=4, 8 words → m_last on beats 3 and 7 only. burst_len=0 → m_last on every beat.
